// File: rtl/arbiter_nmaster.sv
// N-master bus arbiter: fixed-priority or round-robin selection, optional hold-limit
// preemption, and a forced one-cycle all-zero grant gap between any two owners.
module arbiter_nmaster #(
    parameter int NUM_MASTERS = 4,
    parameter bit RR_MODE     = 1'b1,
    parameter int MAX_HOLD    = 0
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_MASTERS-1:0]         breq,
    output logic [NUM_MASTERS-1:0]         bgrant,
    output logic                           grant_valid,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output logic                           preempt
);

    localparam int IDW = $clog2(NUM_MASTERS);
    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_MASTERS - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] bgrant_nxt;
    logic                   valid_nxt;
    logic [IDW-1:0]         id_nxt;
    logic                   preempt_nxt;
    logic [IDW-1:0]         rr_ptr, rr_nxt;
    logic [HCW-1:0]         hold_cnt, hold_nxt;

    logic                   win_found;
    logic [IDW-1:0]         win_id;
    int                     cand;
    logic                   hold_limit;
    logic                   others_req;

    // In round-robin mode the search starts at rr_ptr and wraps at NUM_MASTERS,
    // so a non-power-of-two master count never produces an out-of-range index.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = RR_MODE ? int'(rr_ptr) + i : i;
            if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
            if (!win_found && breq[IDW'(cand)]) begin
                win_found = 1'b1;
                win_id    = IDW'(cand);
            end
        end
    end

    assign hold_limit = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST);
    assign others_req = |(breq & ~bgrant);

    always_comb begin
        state_nxt   = state;
        bgrant_nxt  = bgrant;
        valid_nxt   = grant_valid;
        id_nxt      = grant_id;
        preempt_nxt = 1'b0;
        rr_nxt      = rr_ptr;
        hold_nxt    = hold_cnt;
        unique case (state)
            IDLE: begin
                bgrant_nxt = '0;
                valid_nxt  = 1'b0;
                id_nxt     = '0;
                if (win_found) begin
                    state_nxt          = GRANT;
                    bgrant_nxt[win_id] = 1'b1;
                    valid_nxt          = 1'b1;
                    id_nxt             = win_id;
                    hold_nxt           = '0;
                    rr_nxt             = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
                end
            end
            GRANT: begin
                // An owner drop takes precedence over a coincident hold-limit hit.
                if (!breq[grant_id] || (hold_limit && others_req)) begin
                    state_nxt   = IDLE;
                    bgrant_nxt  = '0;
                    valid_nxt   = 1'b0;
                    id_nxt      = '0;
                    preempt_nxt = breq[grant_id];
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            bgrant      <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            preempt     <= 1'b0;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            bgrant      <= bgrant_nxt;
            grant_valid <= valid_nxt;
            grant_id    <= id_nxt;
            preempt     <= preempt_nxt;
            rr_ptr      <= rr_nxt;
            hold_cnt    <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_arbiter_nmaster.sv
// Scoreboard bench for arbiter_nmaster: four configurations share clk/rstn, stimulus
// queues expected outputs per cycle and a negedge monitor pops and compares them.
module tb_arbiter_nmaster;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] breq_v [4];
    logic [3:0] bg0, bg1, bg3;
    logic [2:0] bg2;
    logic [1:0] id0, id1, id2, id3;
    logic       v0, v1, v2, v3, p0, p1, p2, p3;

    // 0: N=4 round-robin, 1: N=4 fixed, 2: N=3 round-robin, 3: N=4 RR with MAX_HOLD=4
    arbiter_nmaster #(.NUM_MASTERS(4), .RR_MODE(1'b1), .MAX_HOLD(0)) dut_rr (
        .clk(clk), .rstn(rstn), .breq(breq_v[0]), .bgrant(bg0),
        .grant_valid(v0), .grant_id(id0), .preempt(p0));
    arbiter_nmaster #(.NUM_MASTERS(4), .RR_MODE(1'b0), .MAX_HOLD(0)) dut_fx (
        .clk(clk), .rstn(rstn), .breq(breq_v[1]), .bgrant(bg1),
        .grant_valid(v1), .grant_id(id1), .preempt(p1));
    arbiter_nmaster #(.NUM_MASTERS(3), .RR_MODE(1'b1), .MAX_HOLD(0)) dut_r3 (
        .clk(clk), .rstn(rstn), .breq(breq_v[2][2:0]), .bgrant(bg2),
        .grant_valid(v2), .grant_id(id2), .preempt(p2));
    arbiter_nmaster #(.NUM_MASTERS(4), .RR_MODE(1'b1), .MAX_HOLD(4)) dut_ph (
        .clk(clk), .rstn(rstn), .breq(breq_v[3]), .bgrant(bg3),
        .grant_valid(v3), .grant_id(id3), .preempt(p3));

    logic [3:0] gr  [4];
    logic [1:0] gid [4];
    logic       gv  [4];
    logic       gp  [4];
    always_comb begin
        gr[0] = bg0;            gid[0] = id0; gv[0] = v0; gp[0] = p0;
        gr[1] = bg1;            gid[1] = id1; gv[1] = v1; gp[1] = p1;
        gr[2] = {1'b0, bg2};    gid[2] = id2; gv[2] = v2; gp[2] = p2;
        gr[3] = bg3;            gid[3] = id3; gv[3] = v3; gp[3] = p3;
    end

    typedef struct {
        int         cyc;
        int         sel;
        logic [3:0] grant;
        logic       pre;
    } exp_t;

    exp_t  sb[$];
    exp_t  e;
    int    cycle  = 0;
    int    errors = 0;
    int    checks = 0;
    string nm [4] = '{"rr", "fx", "r3", "ph"};

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int id_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return 0;
    endfunction

    // Monitor: structural invariants on every DUT, then scoreboard entries due this cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s onehot c%0d", nm[d], cycle), int'($onehot0(gr[d])), 1);
            check($sformatf("%s valid_cons c%0d", nm[d], cycle), int'(gv[d]), int'(|gr[d]));
            check($sformatf("%s id_cons c%0d", nm[d], cycle), int'(gid[d]), id_of(gr[d]));
        end
        while (sb.size() > 0 && sb[0].cyc <= cycle) begin
            e = sb.pop_front();
            check($sformatf("%s grant c%0d", nm[e.sel], e.cyc), int'(gr[e.sel]), int'(e.grant));
            check($sformatf("%s id c%0d", nm[e.sel], e.cyc), int'(gid[e.sel]), id_of(e.grant));
            check($sformatf("%s valid c%0d", nm[e.sel], e.cyc), int'(gv[e.sel]), int'(|e.grant));
            check($sformatf("%s preempt c%0d", nm[e.sel], e.cyc), int'(gp[e.sel]), int'(e.pre));
        end
    end

    // Drive req for one cycle; eg/ep are the outputs expected after the next edge.
    task automatic cyc(input int s, input logic [3:0] req, input logic [3:0] eg, input logic ep);
        @(posedge clk);
        #1;
        breq_v[s] = req;
        sb.push_back(exp_t'{cyc: cycle + 1, sel: s, grant: eg, pre: ep});
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s %s bgrant", nm[d], tag), int'(gr[d]), 0);
            check($sformatf("%s %s valid", nm[d], tag), int'(gv[d]), 0);
            check($sformatf("%s %s id", nm[d], tag), int'(gid[d]), 0);
            check($sformatf("%s %s preempt", nm[d], tag), int'(gp[d]), 0);
        end
    endtask

    // Assert reset mid-cycle (away from any edge) and check outputs clear at once.
    task automatic do_reset();
        @(posedge clk);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("async_rst");
        for (int d = 0; d < 4; d++) breq_v[d] = 4'b0000;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    logic [3:0] drop;

    initial begin
        for (int d = 0; d < 4; d++) breq_v[d] = 4'b0000;
        #3;
        check_all_zero("por");
        @(negedge clk);
        rstn = 1'b1;

        // single request, then drop: one grant, exactly one zero cycle, stays idle
        cyc(0, 4'b0100, 4'b0100, 1'b0);
        cyc(0, 4'b0100, 4'b0100, 1'b0);
        cyc(0, 4'b0000, 4'b0000, 1'b0);
        cyc(0, 4'b0000, 4'b0000, 1'b0);
        cyc(0, 4'b0000, 4'b0000, 1'b0);

        // grant master 0 (rr_ptr -> 1), then reset mid-grant
        cyc(0, 4'b0001, 4'b0001, 1'b0);
        cyc(0, 4'b0001, 4'b0001, 1'b0);
        do_reset();
        for (int k = 0; k < 10; k++) cyc(0, 4'b0000, 4'b0000, 1'b0);

        // fixed priority: master 1 always wins after its gap
        for (int k = 0; k < 3; k++) begin
            repeat (3) cyc(1, 4'b1110, 4'b0010, 1'b0);
            cyc(1, 4'b1100, 4'b0000, 1'b0);
        end
        cyc(1, 4'b0000, 4'b0000, 1'b0);

        // round-robin N=4 from reset pointer 0: order 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            drop = 4'b1111;
            drop[k % 4] = 1'b0;
            repeat (2) cyc(0, 4'b1111, 4'(1 << (k % 4)), 1'b0);
            cyc(0, drop, 4'b0000, 1'b0);
        end
        cyc(0, 4'b0000, 4'b0000, 1'b0);

        // round-robin N=3: order 0,1,2,0,1 with wrap at 3
        for (int k = 0; k < 5; k++) begin
            drop = 4'b0111;
            drop[k % 3] = 1'b0;
            repeat (2) cyc(2, 4'b0111, 4'(1 << (k % 3)), 1'b0);
            cyc(2, drop, 4'b0000, 1'b0);
        end
        cyc(2, 4'b0000, 4'b0000, 1'b0);

        // preemption: master 0 granted 4 cycles, preempt pulse in gap, then master 3
        cyc(3, 4'b0001, 4'b0001, 1'b0);
        repeat (3) cyc(3, 4'b1001, 4'b0001, 1'b0);
        cyc(3, 4'b1001, 4'b0000, 1'b1);
        cyc(3, 4'b1001, 4'b1000, 1'b0);
        cyc(3, 4'b0001, 4'b0000, 1'b0);
        cyc(3, 4'b0000, 4'b0000, 1'b0);

        // owner drop on the hold-limit edge: plain release, RR pointer (3) picks master 3
        cyc(3, 4'b0100, 4'b0100, 1'b0);
        repeat (3) cyc(3, 4'b1101, 4'b0100, 1'b0);
        cyc(3, 4'b1001, 4'b0000, 1'b0);
        cyc(3, 4'b1001, 4'b1000, 1'b0);
        cyc(3, 4'b0001, 4'b0000, 1'b0);
        cyc(3, 4'b0000, 4'b0000, 1'b0);

        // lone owner keeps grant past the limit; a late requester preempts at once
        cyc(3, 4'b0010, 4'b0010, 1'b0);
        repeat (8) cyc(3, 4'b0010, 4'b0010, 1'b0);
        cyc(3, 4'b1010, 4'b0000, 1'b1);
        cyc(3, 4'b1010, 4'b1000, 1'b0);
        cyc(3, 4'b0000, 4'b0000, 1'b0);
        cyc(3, 4'b0000, 4'b0000, 1'b0);

        repeat (3) @(posedge clk);
        check("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
